fruit_dropper: RTL and testbench
================================

FRUIT_DROPPER -- requirements
Module: fruit_dropper

Interface
REQ-001 The module SHALL have parameter FALL_DIV, default 4: ticks per one-row fall step (1..15).
REQ-002 The module SHALL have parameter Y_BOTTOM, default 119: last fruit row before a miss.
REQ-003 The module SHALL have parameter LFSR_SEED, default 16'hACE1: non-zero LFSR reset value.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  game running; 0 freezes falling.
REQ-007 tick  input  1  one-cycle frame pulse; paces the fall.
REQ-008 hit  input  1  catch indication from the hit detector, sampled each clk.
REQ-009 fruitx, fruitx2 .. fruitx7  output  7 each  column positions of the current fruit row.
REQ-010 fruity  output  7  shared row of all fruit.
REQ-011 colour  output  3  fruit colour; 3'b111 = black/uncatchable.
REQ-012 active  output  1  high while fruit is falling.
REQ-013 caught  output  1  one-cycle pulse on catch.
REQ-014 missed  output  1  one-cycle pulse when fruit passes Y_BOTTOM.

Function
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clk after reset, never reaching zero.
REQ-016 States: IDLE, SPAWN, FALL, CATCH, MISS; all outputs registered.
REQ-017 IDLE: active=0; enable=1 -> SPAWN next cycle.
REQ-018 SPAWN lasts exactly 7 cycles: cycle k (1..7) loads fruitx_k <= lfsr[6:0]; cycle 7 also loads colour <= lfsr[9:7]; fruity <= 0 on entry; then FALL.
REQ-019 SPAWN SHALL complete regardless of enable.
REQ-020 FALL: active=1; each tick with enable=1 increments a divider; when divider reaches current divisor it clears and fruity increments by 1.
REQ-021 FALL with enable=0: divider, fruity and state hold; hit ignored.
REQ-022 FALL, enable=1, hit=1 -> CATCH next cycle; hit has priority over a simultaneous step (fruity not incremented).
REQ-023 FALL, step occurring while fruity==Y_BOTTOM -> MISS next cycle; fruity holds Y_BOTTOM.
REQ-024 CATCH: caught=1 for exactly that cycle; MISS: missed=1 for exactly that cycle; active=0 in both.
REQ-025 From CATCH/MISS: enable=1 -> SPAWN, else IDLE.
REQ-026 Hit-to-caught latency SHALL be 1 cycle; fruity arithmetic is unsigned 7-bit, never wraps.

Reset
REQ-027 reset=1 SHALL immediately (no clk edge) force: state IDLE, fruitx..fruitx7=0, fruity=0, colour=3'b111, active=0, caught=0, missed=0, divider=0, divisor=FALL_DIV, LFSR=LFSR_SEED.
REQ-028 Reset asserted mid-SPAWN or mid-FALL SHALL abandon the fruit; no caught/missed pulse is emitted.

Configuration
REQ-029 With FRUIT_SPEEDUP_EN defined, the divisor SHALL decrement by 1 on each CATCH, saturating at 1, restored to FALL_DIV only by reset.
REQ-030 Without FRUIT_SPEEDUP_EN, the divisor SHALL be constant FALL_DIV and no decrement logic SHALL exist.

Structure
REQ-031 Shared package fruit_pkg SHALL hold the state encoding, COLOUR_BLACK (3'b111), LFSR width and tap constants.
REQ-032 The LFSR SHALL be a sub-module fruit_lfsr (clk, reset, seed, 16-bit state out).

Verification
REQ-033 FALL_DIV=4, tick every cycle, enable=1 from reset: after 7 SPAWN cycles fruitx..fruitx7/colour match a seed-16'hACE1 LFSR model; fruity increments every 4 ticks.
REQ-034 hit=1 while fruity=10 -> caught=1 next cycle for one cycle, then SPAWN, fruity=0, new positions.
REQ-035 No hit: fruity reaches 119, next step -> missed=1 one cycle, fruity stays 119, respawn.
REQ-036 hit and divider step in same cycle at fruity=20 -> CATCH, fruity remains 20.
REQ-037 reset pulsed asynchronously mid-FALL at fruity=50 -> outputs at reset values before next clk edge; no caught/missed.
REQ-038 FRUIT_SPEEDUP_EN, FALL_DIV=4: three catches -> step every 1 tick; fourth catch keeps divisor 1.

Source files
------------

// File: rtl/fruit_pkg.sv
// Shared definitions for the fruit dropper: FSM encoding, colour codes and
// the LFSR polynomial used to randomise spawn positions.
package fruit_pkg;

  // Game FSM states
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSpawn = 3'd1,
    StFall  = 3'd2,
    StCatch = 3'd3,
    StMiss  = 3'd4
  } state_e;

  // Black fruit cannot be caught; also the colour shown while idle.
  localparam logic [2:0] COLOUR_BLACK = 3'b111;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  localparam int unsigned LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Number of fruit columns loaded per spawn.
  localparam int unsigned NUM_FRUIT = 7;

  // One LFSR step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fruit_lfsr.sv
// Free-running 16-bit Fibonacci LFSR. Loads the seed on reset and advances
// every clock afterwards; a non-zero seed keeps it off the all-zero lock-up.
module fruit_lfsr
  import fruit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  // Shift register with asynchronous seed load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= seed;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/fruit_dropper.sv
// Fruit dropper game engine: spawns a row of seven fruit at pseudo-random
// columns, lets the row fall one line every FALL_DIV ticks and reports a
// catch (hit from the detector) or a miss (row falls past Y_BOTTOM).
// Optional feature macro: FRUIT_SPEEDUP_EN -- each catch shortens the fall
// period by one tick (minimum 1) until the next reset.
module fruit_dropper
  import fruit_pkg::*;
#(
  parameter int unsigned       FALL_DIV  = 4,
  parameter int unsigned       Y_BOTTOM  = 119,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic       hit,
  output logic [6:0] fruitx,
  output logic [6:0] fruitx2,
  output logic [6:0] fruitx3,
  output logic [6:0] fruitx4,
  output logic [6:0] fruitx5,
  output logic [6:0] fruitx6,
  output logic [6:0] fruitx7,
  output logic [6:0] fruity,
  output logic [2:0] colour,
  output logic       active,
  output logic       caught,
  output logic       missed
);

  localparam logic [3:0] DivInit = 4'(FALL_DIV);
  localparam logic [6:0] YBot    = 7'(Y_BOTTOM);

  state_e state_q, state_d;

  logic [LFSR_W-1:0] lfsr;
  logic [6:0]        pos_q [NUM_FRUIT];
  logic [6:0]        pos_d [NUM_FRUIT];
  logic [6:0]        y_q, y_d;
  logic [2:0]        colour_q, colour_d;
  logic [2:0]        spawn_q, spawn_d;
  logic [3:0]        div_q, div_d;
  logic [3:0]        divisor;
  logic              active_q, active_d;
  logic              caught_q, caught_d;
  logic              missed_q, missed_d;

  // Only the low ten LFSR bits feed positions and colour.
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[LFSR_W-1:10];

  fruit_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

`ifdef FRUIT_SPEEDUP_EN
  logic [3:0] divisor_q, divisor_d;

  // Each catch speeds the fall up by one tick, never below one
  always_comb begin
    divisor_d = divisor_q;
    if (state_q == StCatch && divisor_q > 4'd1) begin
      divisor_d = divisor_q - 4'd1;
    end
  end

  // Divisor register, only reset restores the starting speed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor_q <= DivInit;
    end else begin
      divisor_q <= divisor_d;
    end
  end

  assign divisor = divisor_q;
`else
  assign divisor = DivInit;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values; outputs are decoded from state_d
  // so that every output is a register aligned with the state it reports.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    y_d      = y_q;
    colour_d = colour_q;
    spawn_d  = spawn_q;
    div_d    = div_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StSpawn;
        end
      end

      StSpawn: begin
        // One column per cycle, so the seven columns see different LFSR values.
        pos_d[spawn_q] = lfsr[6:0];
        if (spawn_q == 3'(NUM_FRUIT - 1)) begin
          colour_d = lfsr[9:7];
          state_d  = StFall;
        end else begin
          spawn_d = spawn_q + 3'd1;
        end
      end

      StFall: begin
        if (enable) begin
          if (hit) begin
            // A catch wins over a simultaneous fall step.
            state_d = StCatch;
          end else if (tick) begin
            if (div_q + 4'd1 == divisor) begin
              div_d = '0;
              if (y_q == YBot) begin
                state_d = StMiss;
              end else begin
                y_d = y_q + 7'd1;
              end
            end else begin
              div_d = div_q + 4'd1;
            end
          end
        end
      end

      StCatch, StMiss: begin
        state_d = enable ? StSpawn : StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // A fresh fruit row always starts at the top with a clean spawn count.
    if (state_d == StSpawn && state_q != StSpawn) begin
      y_d     = '0;
      spawn_d = '0;
    end

    // The divider only counts within one fall.
    if (state_d != StFall) begin
      div_d = '0;
    end

    active_d = (state_d == StFall);
    caught_d = (state_d == StCatch);
    missed_d = (state_d == StMiss);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q    <= '{default: '0};
      y_q      <= '0;
      colour_q <= COLOUR_BLACK;
      spawn_q  <= '0;
      div_q    <= '0;
      active_q <= 1'b0;
      caught_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      spawn_q  <= spawn_d;
      div_q    <= div_d;
      active_q <= active_d;
      caught_q <= caught_d;
      missed_q <= missed_d;
    end
  end

  assign fruitx  = pos_q[0];
  assign fruitx2 = pos_q[1];
  assign fruitx3 = pos_q[2];
  assign fruitx4 = pos_q[3];
  assign fruitx5 = pos_q[4];
  assign fruitx6 = pos_q[5];
  assign fruitx7 = pos_q[6];
  assign fruity  = y_q;
  assign colour  = colour_q;
  assign active  = active_q;
  assign caught  = caught_q;
  assign missed  = missed_q;

endmodule

// File: tb/tb_fruit_dropper.sv
// Directed bench for fruit_dropper: spawn positions against an independent
// LFSR model, fall rate, enable freeze, catch, hit/step priority, miss at the
// bottom row, asynchronous reset mid-fall, and the divisor across catches
// (FRUIT_SPEEDUP_EN changes the expected speed-up).
module tb_fruit_dropper;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       tick;
  logic       hit;
  logic [6:0] fruitx, fruitx2, fruitx3, fruitx4, fruitx5, fruitx6, fruitx7;
  logic [6:0] fruity;
  logic [2:0] colour;
  logic       active, caught, missed;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_div  = 4;

  logic [15:0] m_lfsr;

  fruit_dropper #(
    .FALL_DIV  (4),
    .Y_BOTTOM  (119),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .tick    (tick),
    .hit     (hit),
    .fruitx  (fruitx),
    .fruitx2 (fruitx2),
    .fruitx3 (fruitx3),
    .fruitx4 (fruitx4),
    .fruitx5 (fruitx5),
    .fruitx6 (fruitx6),
    .fruitx7 (fruitx7),
    .fruity  (fruity),
    .colour  (colour),
    .active  (active),
    .caught  (caught),
    .missed  (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, seeded 0xACE1
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bump_div();
`ifdef FRUIT_SPEEDUP_EN
    if (cur_div > 1) cur_div--;
`endif
  endtask

  // Called in spawn cycle 1; runs the 7 spawn cycles and checks the new row.
  task automatic spawn_check(input string tag);
    logic [6:0] ep [7];
    logic [2:0] ec;
    ec = 3'd0;
    check({tag, "_spawn_act"}, int'(active), 0);
    check({tag, "_spawn_y"}, int'(fruity), 0);
    for (int k = 0; k < 7; k++) begin
      ep[k] = m_lfsr[6:0];
      if (k == 6) ec = m_lfsr[9:7];
      run(1);
    end
    check({tag, "_x1"}, int'(fruitx), int'(ep[0]));
    check({tag, "_x2"}, int'(fruitx2), int'(ep[1]));
    check({tag, "_x3"}, int'(fruitx3), int'(ep[2]));
    check({tag, "_x4"}, int'(fruitx4), int'(ep[3]));
    check({tag, "_x5"}, int'(fruitx5), int'(ep[4]));
    check({tag, "_x6"}, int'(fruitx6), int'(ep[5]));
    check({tag, "_x7"}, int'(fruitx7), int'(ep[6]));
    check({tag, "_col"}, int'(colour), int'(ec));
    check({tag, "_fall_act"}, int'(active), 1);
    check({tag, "_fall_y"}, int'(fruity), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    tick   = 1'b1;
    hit    = 1'b0;
    #2;
    check("rst_x1", int'(fruitx), 0);
    check("rst_x7", int'(fruitx7), 0);
    check("rst_y", int'(fruity), 0);
    check("rst_col", int'(colour), 7);
    check("rst_act", int'(active), 0);
    check("rst_caught", int'(caught), 0);
    check("rst_missed", int'(missed), 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle with enable low
    run(3);
    check("idle_act", int'(active), 0);
    check("idle_col", int'(colour), 7);

    // Start the game: next edge enters SPAWN
    enable = 1'b1;
    run(1);
    spawn_check("s1");

    // Fall rate and enable freeze (divisor 4, no catches yet)
    run(3);
    check("fall_y0", int'(fruity), 0);
    run(1);
    check("fall_y1", int'(fruity), 1);
    run(2);
    enable = 1'b0;
    hit    = 1'b1;
    run(5);
    check("frz_y", int'(fruity), 1);
    check("frz_act", int'(active), 1);
    check("frz_caught", int'(caught), 0);
    enable = 1'b1;
    hit    = 1'b0;
    run(1);
    check("thaw_y1", int'(fruity), 1);
    run(1);
    check("thaw_y2", int'(fruity), 2);

    // Catch at row 10
    run(8 * cur_div);
    check("c10_y", int'(fruity), 10);
    hit = 1'b1;
    run(1);
    hit = 1'b0;
    check("c10_caught", int'(caught), 1);
    check("c10_act", int'(active), 0);
    check("c10_y_hold", int'(fruity), 10);
    bump_div();
    run(1);
    check("c10_pulse_end", int'(caught), 0);
    spawn_check("s2");

    // Hit coinciding with a fall step at row 20
    run(20 * cur_div + cur_div - 1);
    check("c20_y", int'(fruity), 20);
    hit = 1'b1;
    run(1);
    hit = 1'b0;
    check("c20_caught", int'(caught), 1);
    check("c20_y_hold", int'(fruity), 20);
    bump_div();
    run(1);
    spawn_check("s3");

    // Miss past the bottom row
    run(119 * cur_div);
    check("miss_y119", int'(fruity), 119);
    run(cur_div - 1);
    check("miss_pre", int'(missed), 0);
    run(1);
    check("miss_pulse", int'(missed), 1);
    check("miss_y_hold", int'(fruity), 119);
    check("miss_act", int'(active), 0);
    check("miss_caught", int'(caught), 0);
    run(1);
    check("miss_pulse_end", int'(missed), 0);
    spawn_check("s4");

    // Asynchronous reset mid-fall at row 50
    run(50 * cur_div);
    check("ar_y50", int'(fruity), 50);
    #3;
    reset = 1'b1;
    #1;
    check("ar_y", int'(fruity), 0);
    check("ar_x1", int'(fruitx), 0);
    check("ar_x4", int'(fruitx4), 0);
    check("ar_col", int'(colour), 7);
    check("ar_act", int'(active), 0);
    check("ar_caught", int'(caught), 0);
    check("ar_missed", int'(missed), 0);
    run(1);
    check("ar_hold_caught", int'(caught), 0);
    check("ar_hold_missed", int'(missed), 0);
    @(negedge clk);
    reset   = 1'b0;
    cur_div = 4;
    run(1);
    spawn_check("s5");

    // Divisor across repeated catches
    for (int c = 0; c < 4; c++) begin
      run(cur_div - 1);
      check($sformatf("sp%0d_y0", c), int'(fruity), 0);
      run(1);
      check($sformatf("sp%0d_y1", c), int'(fruity), 1);
      hit = 1'b1;
      run(1);
      hit = 1'b0;
      check($sformatf("sp%0d_caught", c), int'(caught), 1);
      bump_div();
      run(1);
      spawn_check($sformatf("sp%0d", c));
    end
    run(cur_div - 1);
    check("sp_final_y0", int'(fruity), 0);
    run(1);
    check("sp_final_y1", int'(fruity), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
